// File: rtl/hit_judge.sv
// hit_judge: per-lane arrow queues, press/miss judgement, per-lane result buffers and a
// fixed-priority output arbiter. Define COMBO_EN to add the saturating combo counter port.
module hit_judge #(
  parameter int POS_W       = 9,
  parameter int TARGET      = 400,
  parameter int PERFECT_WIN = 4,
  parameter int GREAT_WIN   = 10,
  parameter int GOOD_WIN    = 20,
  parameter int DEPTH       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       spawn_stb,
  input  logic [4:0] arr,
  input  logic [3:0] pressed,
  output logic [1:0] score,
  output logic       update,
  output logic       overflow,
`ifdef COMBO_EN
  output logic [7:0] combo,
`endif
  output logic [3:0] live
);

  localparam int LANES = 4;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [POS_W-1:0] POS_MAX  = {POS_W{1'b1}};
  localparam logic [POS_W-1:0] TGT      = POS_W'(TARGET);
  localparam logic [POS_W-1:0] MISS_LIM = POS_W'(TARGET + GOOD_WIN);
  localparam logic [POS_W-1:0] PERF_D   = POS_W'(PERFECT_WIN);
  localparam logic [POS_W-1:0] GREAT_D  = POS_W'(GREAT_WIN);
  localparam logic [POS_W-1:0] GOOD_D   = POS_W'(GOOD_WIN);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [LANES-1:0] w_pop;
  logic [LANES-1:0] w_push;
  logic [LANES-1:0] w_pushDrop;
  logic [1:0]       w_evScore [LANES];

  logic [LANES-1:0] r_evValid;
  logic [1:0]       r_evScore [LANES];
  logic [LANES-1:0] r_bufValid;
  logic [1:0]       r_bufScore [LANES];
  logic [1:0]       r_score;
  logic             r_update;
  logic             r_overflow;

  logic [LANES-1:0] w_grant;
  logic [1:0]       w_grantScore;
  logic             w_resultDrop;
  logic             w_emit;

  for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
    logic [POS_W-1:0] r_pos [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [CNT_W-1:0] r_count;

    logic [POS_W-1:0] w_headPos;
    logic [POS_W-1:0] w_dist;
    logic [PTR_W-1:0] w_tail;
    logic [DEPTH-1:0] w_entryLive;
    logic             w_nonEmpty;
    logic             w_full;
    logic             w_spawnHere;
    logic             w_miss;
    logic             w_hit;

    assign w_nonEmpty  = (r_count != '0);
    assign w_full      = (r_count == CNT_FULL);
    assign w_headPos   = r_pos[r_head];
    assign w_tail      = r_head + r_count[PTR_W-1:0];
    assign w_dist      = (w_headPos >= TGT) ? (w_headPos - TGT) : (TGT - w_headPos);
    assign w_spawnHere = spawn_stb && arr[4] && arr[gl];

    // A miss pre-empts a press on the same head; early presses outside the window are ignored.
    assign w_miss = w_nonEmpty && (w_headPos > MISS_LIM);
    assign w_hit  = pressed[gl] && w_nonEmpty && !w_miss && (w_dist <= GOOD_D);

    assign w_pop[gl]      = w_miss || w_hit;
    assign w_push[gl]     = w_spawnHere && !w_full;
    assign w_pushDrop[gl] = w_spawnHere && w_full;
    assign w_evScore[gl]  = w_miss             ? 2'd0 :
                            (w_dist <= PERF_D)  ? 2'd3 :
                            (w_dist <= GREAT_D) ? 2'd2 : 2'd1;
    assign live[gl]       = w_nonEmpty;

    for (genvar ge = 0; ge < DEPTH; ge++) begin : g_entry
      logic [PTR_W-1:0] w_offset;
      assign w_offset        = PTR_W'(ge) - r_head;
      assign w_entryLive[ge] = ({1'b0, w_offset} < r_count);
    end

    // The freshly pushed slot sits outside the live window, so tick never advances it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_head  <= '0;
        r_count <= '0;
        for (int e = 0; e < DEPTH; e++) begin
          r_pos[e] <= '0;
        end
      end else begin
        for (int e = 0; e < DEPTH; e++) begin
          if (tick && w_entryLive[e] && (r_pos[e] != POS_MAX)) begin
            r_pos[e] <= r_pos[e] + POS_W'(1);
          end
        end
        if (w_push[gl]) begin
          r_pos[w_tail] <= '0;
        end
        if (w_pop[gl]) begin
          r_head <= r_head + PTR_W'(1);
        end
        r_count <= r_count + CNT_W'(w_push[gl]) - CNT_W'(w_pop[gl]);
      end
    end
  end

  assign w_grant      = r_bufValid & (~r_bufValid + LANES'(1));
  assign w_emit       = |r_bufValid;
  assign w_resultDrop = |(r_evValid & r_bufValid & ~w_grant);

  always_comb begin
    w_grantScore = '0;
    for (int l = 0; l < LANES; l++) begin
      if (w_grant[l]) begin
        w_grantScore = r_bufScore[l];
      end
    end
  end

  // A buffer being emitted this cycle can accept the next result; otherwise it is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_evValid  <= '0;
      r_bufValid <= '0;
      r_score    <= '0;
      r_update   <= 1'b0;
      r_overflow <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        r_evScore[l]  <= '0;
        r_bufScore[l] <= '0;
      end
    end else begin
      r_evValid <= w_pop;
      for (int l = 0; l < LANES; l++) begin
        r_evScore[l] <= w_evScore[l];
        if (r_evValid[l] && (!r_bufValid[l] || w_grant[l])) begin
          r_bufValid[l] <= 1'b1;
          r_bufScore[l] <= r_evScore[l];
        end else if (w_grant[l]) begin
          r_bufValid[l] <= 1'b0;
        end
      end
      r_update <= w_emit;
      if (w_emit) begin
        r_score <= w_grantScore;
      end
      if ((|w_pushDrop) || w_resultDrop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef COMBO_EN
  logic [7:0] r_combo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_combo <= '0;
    end else if (w_emit) begin
      if (w_grantScore == 2'd0) begin
        r_combo <= '0;
      end else if (r_combo != 8'hFF) begin
        r_combo <= r_combo + 8'd1;
      end
    end
  end

  assign combo = r_combo;
`endif

  assign score    = r_score;
  assign update   = r_update;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_hit_judge.sv
// Testbench for hit_judge: queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed scores and latencies.
module tb_hit_judge;

  localparam int TARGET   = 400;
  localparam int MISS_LIM = 420;
  localparam int POS_MAX  = 511;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       spawnStb;
  logic [4:0] arr;
  logic [3:0] pressed;
  logic [1:0] score;
  logic       update;
  logic       overflow;
  logic [3:0] live;

  int errors = 0;
  int checks = 0;
  bit modelArmed = 1'b0;

  always #5 clk = ~clk;

  hit_judge dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .spawn_stb(spawnStb),
    .arr      (arr),
    .pressed  (pressed),
    .score    (score),
    .update   (update),
    .overflow (overflow),
    .live     (live)
  );

  // Reference model: arrow positions as plain queues, results as pending per-lane slots.
  int mq [4][$];
  bit mEvV [4];
  int mEvS [4];
  bit mBufV [4];
  int mBufS [4];
  bit expUpd;
  int expScore;
  bit expOvf;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int windowScore(input int d);
    if (d <= 4) return 3;
    if (d <= 10) return 2;
    return 1;
  endfunction

  task automatic modelReset();
    for (int l = 0; l < 4; l++) begin
      mq[l].delete();
      mEvV[l] = 1'b0;
      mEvS[l] = 0;
      mBufV[l] = 1'b0;
      mBufS[l] = 0;
    end
    expUpd = 1'b0;
    expScore = 0;
    expOvf = 1'b0;
  endtask

  task automatic modelStep();
    bit granted = 1'b0;
    int preSize;
    int h;
    int d;
    expUpd = 1'b0;
    for (int l = 0; l < 4; l++) begin
      if (!granted && mBufV[l]) begin
        granted = 1'b1;
        expUpd = 1'b1;
        expScore = mBufS[l];
        mBufV[l] = 1'b0;
      end
    end
    for (int l = 0; l < 4; l++) begin
      if (mEvV[l]) begin
        if (mBufV[l]) expOvf = 1'b1;
        else begin
          mBufV[l] = 1'b1;
          mBufS[l] = mEvS[l];
        end
      end
    end
    for (int l = 0; l < 4; l++) begin
      mEvV[l] = 1'b0;
      preSize = mq[l].size();
      if (preSize > 0) begin
        h = mq[l][0];
        d = (h >= TARGET) ? h - TARGET : TARGET - h;
        if (h > MISS_LIM) begin
          mEvV[l] = 1'b1;
          mEvS[l] = 0;
        end else if (pressed[l] && d <= 20) begin
          mEvV[l] = 1'b1;
          mEvS[l] = windowScore(d);
        end
        if (mEvV[l]) void'(mq[l].pop_front());
      end
      if (tick) begin
        for (int k = 0; k < mq[l].size(); k++) begin
          if (mq[l][k] < POS_MAX) mq[l][k] = mq[l][k] + 1;
        end
      end
      if (spawnStb && arr[4] && arr[l]) begin
        if (preSize == 4) expOvf = 1'b1;
        else mq[l].push_back(0);
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) modelReset();
    else modelStep();
  end

  task automatic checkOutput();
    int expLive = 0;
    for (int l = 0; l < 4; l++) begin
      if (mq[l].size() != 0) expLive |= (1 << l);
    end
    check("cycle update", int'(update), int'(expUpd));
    check("cycle score", int'(score), expScore);
    check("cycle overflow", int'(overflow), int'(expOvf));
    check("cycle live", int'(live), expLive);
  endtask

  always @(negedge clk) begin
    if (!reset && modelArmed) checkOutput();
  end

  // Drives one cycle of inputs across a single rising edge.
  task automatic applyStimulus(input bit s, input logic [4:0] a, input logic [3:0] p, input bit t);
    spawnStb = s;
    arr = a;
    pressed = p;
    tick = t;
    @(posedge clk);
    #1;
    spawnStb = 1'b0;
    arr = '0;
    pressed = '0;
    tick = 1'b0;
  endtask

  task automatic doTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'b0, 4'b0, 1'b1);
  endtask

  task automatic waitUpdate(input string name, input int expS, input int expLat);
    int lat = -1;
    for (int i = 1; i <= 12 && lat < 0; i++) begin
      @(negedge clk);
      if (update) begin
        lat = i - 1;
        check({name, " score"}, int'(score), expS);
      end
    end
    check({name, " seen"}, int'(lat >= 0), 1);
    if (lat >= 0) check({name, " latency"}, lat, expLat);
  endtask

  task automatic countUpdates(input string name, input int n, input int expCount, input int expS);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (update) begin
        cnt++;
        check({name, " score"}, int'(score), expS);
      end
    end
    check({name, " count"}, cnt, expCount);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    tick = 1'b0;
    spawnStb = 1'b0;
    arr = '0;
    pressed = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset update", int'(update), 0);
    check("reset score", int'(score), 0);
    check("reset overflow", int'(overflow), 0);
    check("reset live", int'(live), 0);
    reset = 1'b0;
    modelArmed = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] perfect hit on up lane");
    applyStimulus(1'b1, 5'b10001, 4'b0, 1'b0);
    check("spawn live0", int'(live), 1);
    doTicks(400);
    applyStimulus(1'b0, 5'b0, 4'b0001, 1'b0);
    waitUpdate("perfect", 3, 2);
    check("perfect live", int'(live), 0);

    $display("[TB] great and good on left lane");
    applyStimulus(1'b1, 5'b10100, 4'b0, 1'b0);
    doTicks(390);
    applyStimulus(1'b0, 5'b0, 4'b0100, 1'b0);
    waitUpdate("great", 2, 2);
    applyStimulus(1'b1, 5'b10100, 4'b0, 1'b0);
    doTicks(382);
    applyStimulus(1'b0, 5'b0, 4'b0100, 1'b0);
    waitUpdate("good", 1, 2);

    $display("[TB] miss on right lane, press on empty lane");
    applyStimulus(1'b1, 5'b11000, 4'b0, 1'b0);
    doTicks(421);
    waitUpdate("miss", 0, 3);
    applyStimulus(1'b0, 5'b0, 4'b1000, 1'b0);
    countUpdates("empty press", 6, 0, 0);

    $display("[TB] simultaneous presses in all lanes");
    applyStimulus(1'b1, 5'b11111, 4'b0, 1'b0);
    check("all live", int'(live), 15);
    doTicks(400);
    applyStimulus(1'b0, 5'b0, 4'b1111, 1'b0);
    waitUpdate("quad first", 3, 2);
    countUpdates("quad rest", 6, 3, 3);

    $display("[TB] queue overflow on down lane");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 5'b10010, 4'b0, 1'b0);
    check("overflow set", int'(overflow), 1);
    check("overflow live", int'(live), 2);
    doTicks(421);
    countUpdates("drain misses", 10, 4, 0);
    check("overflow sticky", int'(overflow), 1);

    $display("[TB] asynchronous reset while busy");
    applyStimulus(1'b1, 5'b10111, 4'b0, 1'b0);
    doTicks(400);
    applyStimulus(1'b0, 5'b0, 4'b0011, 1'b0);
    applyStimulus(1'b0, 5'b0, 4'b0, 1'b0);
    applyStimulus(1'b0, 5'b0, 4'b0, 1'b0);
    check("busy update", int'(update), 1);
    check("busy live", int'(live), 4);
    #2;
    reset = 1'b1;
    #1;
    check("async update", int'(update), 0);
    check("async live", int'(live), 0);
    check("async overflow", int'(overflow), 0);
    check("async score", int'(score), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    countUpdates("post reset quiet", 4, 0, 0);
    @(posedge clk);
    #1;

    $display("[TB] window boundaries");
    applyStimulus(1'b1, 5'b10001, 4'b0, 1'b0);
    doTicks(404);
    applyStimulus(1'b0, 5'b0, 4'b0001, 1'b0);
    waitUpdate("late perfect edge", 3, 2);
    applyStimulus(1'b1, 5'b10010, 4'b0, 1'b0);
    doTicks(395);
    applyStimulus(1'b0, 5'b0, 4'b0010, 1'b0);
    waitUpdate("early great edge", 2, 2);
    applyStimulus(1'b1, 5'b10100, 4'b0, 1'b0);
    doTicks(379);
    applyStimulus(1'b0, 5'b0, 4'b0100, 1'b0);
    countUpdates("too early press", 5, 0, 0);
    check("too early live", int'(live), 4);
    @(posedge clk);
    #1;
    doTicks(42);
    waitUpdate("late miss", 0, 3);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
